// File: rtl/reg_file_seq_4x9.sv
// reg_file_seq_4x9
// Initiator-side sequencer for a 4-entry x 9-bit register file with two read
// ports and one write port. It accepts one 9-bit instruction at a time over a
// valid/ready handshake. Each instruction runs as IDLE -> READ -> WRITE -> IDLE.
//
// Instruction format: [8:6] op, [5:4] rd, [3:2] rs0, [1:0] rs1.
// For LDI, bits [3:0] are the 4-bit immediate.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   in_valid     instruction valid
//   in_instr     instruction word
//   in_ready     high in IDLE; the block can accept an instruction
//   rf_rd0_addr  read address 0 to the file (rs0)
//   rf_rd1_addr  read address 1 to the file (rs1)
//   rf_rd0_data  read data 0 from the file
//   rf_rd1_data  read data 1 from the file
//   rf_wr_en     write enable; one cycle, in WRITE, and never for NOP
//   rf_wr_addr   write address (rd)
//   rf_wr_data   write data (the latched result)
//   done         one-cycle pulse in the IDLE cycle after each instruction
//   flags        {carry, zero} of the last writing instruction
//
// Optional feature: define REG_FILE_SEQ_FLAGS_EN to build the flag logic.
// Without it, flags is tied to 2'b00.
//
// The file commits writes on the falling clock edge. That edge falls inside
// the WRITE cycle, so the next READ always sees the new value.
module reg_file_seq_4x9 (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [8:0] in_instr,
  output logic       in_ready,
  output logic [1:0] rf_rd0_addr,
  output logic [1:0] rf_rd1_addr,
  input  logic [8:0] rf_rd0_data,
  input  logic [8:0] rf_rd1_data,
  output logic       rf_wr_en,
  output logic [1:0] rf_wr_addr,
  output logic [8:0] rf_wr_data,
  output logic       done,
  output logic [1:0] flags
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_MOV = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_LDI = 3'b110;
  localparam logic [2:0] OP_SHL = 3'b111;

  // 9-bit result; all arithmetic wraps modulo 512.
  function automatic logic [8:0] alu_result(input logic [2:0] op,
                                            input logic [8:0] a,
                                            input logic [8:0] b,
                                            input logic [3:0] imm);
    logic [8:0] r;
    case (op)
      OP_NOP:  r = 9'd0;
      OP_MOV:  r = a;
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_LDI:  r = {5'b0_0000, imm};
      OP_SHL:  r = {a[7:0], 1'b0};
      default: r = 9'd0;
    endcase
    return r;
  endfunction

`ifdef REG_FILE_SEQ_FLAGS_EN
  // ADD carries out exactly when the wrapped 9-bit sum is smaller than an operand.
  // SUB reports a borrow. SHL reports the bit shifted out.
  function automatic logic alu_carry(input logic [2:0] op,
                                     input logic [8:0] a,
                                     input logic [8:0] b);
    logic c;
    case (op)
      OP_ADD:  c = ((a + b) < a);
      OP_SUB:  c = (a < b);
      OP_SHL:  c = a[8];
      default: c = 1'b0;
    endcase
    return c;
  endfunction
`endif

  state_e     state_q;
  logic [8:0] instr_q;
  logic       in_ready_q;
  logic [1:0] rd0_addr_q;
  logic [1:0] rd1_addr_q;
  logic       wr_en_q;
  logic [1:0] wr_addr_q;
  logic [8:0] wr_data_q;   // also serves as the latched result register
  logic       done_q;
  logic [8:0] alu_result_d;

  // Compute the result from the file's read data and the captured instruction.
  always_comb begin
    alu_result_d = 9'd0;
    alu_result_d = alu_result(instr_q[8:6], rf_rd0_data, rf_rd1_data, instr_q[3:0]);
  end

`ifdef REG_FILE_SEQ_FLAGS_EN
  logic       carry_q;
  logic [1:0] flags_q;
  logic       alu_carry_d;

  // Compute the carry from the same operands as the result.
  always_comb begin
    alu_carry_d = 1'b0;
    alu_carry_d = alu_carry(instr_q[8:6], rf_rd0_data, rf_rd1_data);
  end
`endif

  // Sequencer FSM. All outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      instr_q    <= 9'd0;
      in_ready_q <= 1'b1;
      rd0_addr_q <= 2'd0;
      rd1_addr_q <= 2'd0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= 2'd0;
      wr_data_q  <= 9'd0;
      done_q     <= 1'b0;
`ifdef REG_FILE_SEQ_FLAGS_EN
      carry_q    <= 1'b0;
      flags_q    <= 2'b00;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (in_valid) begin
            instr_q    <= in_instr;
            // Addresses come from the captured word, not from live in_instr.
            // They stay stable through READ and WRITE.
            rd0_addr_q <= in_instr[3:2];
            rd1_addr_q <= in_instr[1:0];
            in_ready_q <= 1'b0;
            state_q    <= ST_READ;
          end else begin
            in_ready_q <= 1'b1;
            state_q    <= ST_IDLE;
          end
        end
        ST_READ: begin
          wr_data_q <= alu_result_d;
          wr_addr_q <= instr_q[5:4];
          wr_en_q   <= (instr_q[8:6] != OP_NOP);
`ifdef REG_FILE_SEQ_FLAGS_EN
          carry_q   <= alu_carry_d;
`endif
          state_q   <= ST_WRITE;
        end
        ST_WRITE: begin
          wr_en_q    <= 1'b0;
          done_q     <= 1'b1;
          in_ready_q <= 1'b1;
`ifdef REG_FILE_SEQ_FLAGS_EN
          // NOP leaves the flags of the previous writing instruction in place.
          if (instr_q[8:6] != OP_NOP) begin
            flags_q <= {carry_q, (wr_data_q == 9'd0)};
          end else begin
            flags_q <= flags_q;
          end
`endif
          state_q    <= ST_IDLE;
        end
        default: begin
          wr_en_q    <= 1'b0;
          done_q     <= 1'b0;
          in_ready_q <= 1'b1;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign rf_rd0_addr = rd0_addr_q;
  assign rf_rd1_addr = rd1_addr_q;
  assign rf_wr_en    = wr_en_q;
  assign rf_wr_addr  = wr_addr_q;
  assign rf_wr_data  = wr_data_q;
  assign done        = done_q;
`ifdef REG_FILE_SEQ_FLAGS_EN
  assign flags       = flags_q;
`else
  assign flags       = 2'b00;
`endif

endmodule

// File: tb/tb_reg_file_seq_4x9.sv
// Bench for reg_file_seq_4x9.
// A small register-file model writes on the falling edge and reads
// combinationally. The driver pushes the hand-computed write, flags and
// accept cycle of each instruction into a queue. A monitor pops one entry per
// done pulse. It compares that entry with the write seen in the cycle before
// done.
module tb_reg_file_seq_4x9;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [8:0] in_instr;
  logic       in_ready;
  logic [1:0] rf_rd0_addr;
  logic [1:0] rf_rd1_addr;
  logic [8:0] rf_rd0_data;
  logic [8:0] rf_rd1_data;
  logic       rf_wr_en;
  logic [1:0] rf_wr_addr;
  logic [8:0] rf_wr_data;
  logic       done;
  logic [1:0] flags;

`ifdef REG_FILE_SEQ_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  typedef struct {
    logic       en;
    logic [1:0] addr;
    logic [8:0] data;
    logic [1:0] fl;
    int         acc;
  } exp_t;

  exp_t       sb_q[$];
  int         n_tests  = 0;
  int         n_fail   = 0;
  int         n_done   = 0;
  int         n_pushed = 0;
  int         cyc      = 0;
  int         last_acc = 0;
  logic [8:0] rf_mem [4];

  reg_file_seq_4x9 dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_instr   (in_instr),
    .in_ready   (in_ready),
    .rf_rd0_addr(rf_rd0_addr),
    .rf_rd1_addr(rf_rd1_addr),
    .rf_rd0_data(rf_rd0_data),
    .rf_rd1_data(rf_rd1_data),
    .rf_wr_en   (rf_wr_en),
    .rf_wr_addr (rf_wr_addr),
    .rf_wr_data (rf_wr_data),
    .done       (done),
    .flags      (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Register-file model: reset clears it, writes on the falling edge.
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) rf_mem[i] <= 9'd0;
    end else if (rf_wr_en) begin
      rf_mem[rf_wr_addr] <= rf_wr_data;
    end
  end

  assign rf_rd0_data = rf_mem[rf_rd0_addr];
  assign rf_rd1_data = rf_mem[rf_rd1_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: on each done pulse, check the write made in the preceding cycle.
  initial begin
    logic       prev_en;
    logic [1:0] prev_addr;
    logic [8:0] prev_data;
    exp_t       e;
    prev_en   = 1'b0;
    prev_addr = 2'd0;
    prev_data = 9'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_en = 1'b0;
      end else begin
        if (done) begin
          if (sb_q.size() == 0) begin
            n_tests = n_tests + 1;
            n_fail  = n_fail + 1;
            $display("FAIL done_unexpected: got done=1 at cycle %0d, expected no pending instruction", cyc);
          end else begin
            e = sb_q.pop_front();
            n_done = n_done + 1;
            check($sformatf("wr_en#%0d", n_done), prev_en, e.en);
            if (e.en) begin
              check($sformatf("wr_addr#%0d", n_done), prev_addr, e.addr);
              check($sformatf("wr_data#%0d", n_done), prev_data, e.data);
            end
            check($sformatf("flags#%0d", n_done), flags, e.fl);
            check($sformatf("latency#%0d", n_done), cyc - e.acc, 2);
          end
        end
        prev_en   = rf_wr_en;
        prev_addr = rf_wr_addr;
        prev_data = rf_wr_data;
      end
    end
  end

  // Drive one instruction and wait for it to be accepted. The task returns at
  // the falling edge right after the accepting clock edge.
  task automatic issue(input logic [8:0] ins, input bit hold, input logic en,
                       input logic [1:0] addr, input logic [8:0] data,
                       input logic [1:0] fl, input bit push);
    int   t;
    exp_t e;
    t        = 0;
    in_valid = 1'b1;
    in_instr = ins;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      n_tests = n_tests + 1;
      n_fail  = n_fail + 1;
      $display("FAIL accept_timeout: got no in_ready in 20 cycles, expected in_ready=1");
    end
    @(negedge clk);
    last_acc = cyc;
    check("ready_low_after_accept", in_ready, 1'b0);
    if (!hold) in_valid = 1'b0;
    if (push) begin
      e.en   = en;
      e.addr = addr;
      e.data = data;
      e.fl   = FLAGS_ON ? fl : 2'b00;
      e.acc  = cyc;
      sb_q.push_back(e);
      n_pushed++;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      n_tests = n_tests + 1;
      n_fail  = n_fail + 1;
      $display("FAIL drain_timeout: got %0d pending, expected 0", sb_q.size());
    end
    @(negedge clk);
  endtask

  initial begin
    logic [8:0] shl_exp [5];
    int         acc_prev;
    shl_exp[0] = 9'd30;
    shl_exp[1] = 9'd60;
    shl_exp[2] = 9'd120;
    shl_exp[3] = 9'd240;
    shl_exp[4] = 9'd480;

    rst      = 1'b1;
    in_valid = 1'b0;
    in_instr = 9'd0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_wr_en", rf_wr_en, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_flags", flags, 2'b00);
    check("rst_rd0_addr", rf_rd0_addr, 2'd0);
    check("rst_wr_data", rf_wr_data, 9'd0);
    rst = 1'b0;
    @(negedge clk);

    // LDI r1,13
    issue(9'b110_01_1101, 1'b0, 1'b1, 2'd1, 9'd13, 2'b00, 1'b1);
    drain();
    check("file_r1", rf_mem[1], 9'd13);

    // ADD r2,r1,r1, then SUB r3,r0,r1 (0-13 wraps to 499 with a borrow)
    issue(9'b010_10_01_01, 1'b0, 1'b1, 2'd2, 9'd26, 2'b00, 1'b1);
    issue(9'b011_11_00_01, 1'b0, 1'b1, 2'd3, 9'd499, 2'b10, 1'b1);
    drain();

    // LDI r0,15, then five SHL r0,r0, then a sixth one that carries out
    issue(9'b110_00_1111, 1'b0, 1'b1, 2'd0, 9'd15, 2'b00, 1'b1);
    for (int i = 0; i < 5; i++)
      issue(9'b111_00_00_00, 1'b0, 1'b1, 2'd0, shl_exp[i], 2'b00, 1'b1);
    issue(9'b111_00_00_00, 1'b0, 1'b1, 2'd0, 9'd448, 2'b10, 1'b1);
    drain();
    check("file_r0_shl", rf_mem[0], 9'd448);

    // Back-to-back with in_valid held high: MOV r2,r0; AND r3,r2,r1 (zero);
    // NOP (flags hold); OR r3,r2,r1
    issue(9'b001_10_00_00, 1'b1, 1'b1, 2'd2, 9'd448, 2'b00, 1'b1);
    acc_prev = last_acc;
    issue(9'b100_11_10_01, 1'b1, 1'b1, 2'd3, 9'd0, 2'b01, 1'b1);
    check("b2b_gap1", last_acc - acc_prev, 3);
    acc_prev = last_acc;
    issue(9'b000_00_00_00, 1'b1, 1'b0, 2'd0, 9'd0, 2'b01, 1'b1);
    check("b2b_gap2", last_acc - acc_prev, 3);
    acc_prev = last_acc;
    issue(9'b101_11_10_01, 1'b0, 1'b1, 2'd3, 9'd461, 2'b00, 1'b1);
    check("b2b_gap3", last_acc - acc_prev, 3);
    drain();
    check("file_r3_or", rf_mem[3], 9'd461);

    // SUB r1,r1,r1 with r1=13 gives zero, with no borrow
    issue(9'b011_01_01_01, 1'b0, 1'b1, 2'd1, 9'd0, 2'b01, 1'b1);
    drain();
    check("file_r1_zero", rf_mem[1], 9'd0);

    // Reset in the middle of the READ of ADD r2,r1,r1
    issue(9'b010_10_01_01, 1'b0, 1'b1, 2'd2, 9'd0, 2'b00, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_done", done, 1'b0);
    check("abort_flags", flags, 2'b00);
    check("abort_wr_en", rf_wr_en, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("abort_quiet_wr_en%0d", i), rf_wr_en, 1'b0);
      check($sformatf("abort_quiet_done%0d", i), done, 1'b0);
    end

    // Recovery: LDI r2,5
    issue(9'b110_10_0101, 1'b0, 1'b1, 2'd2, 9'd5, 2'b00, 1'b1);
    drain();
    check("file_r2_recover", rf_mem[2], 9'd5);
    check("done_count", n_done, n_pushed);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running at 100000, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
